// File: rtl/reg_cmd_sequencer_if.sv
// Bundle of the host command/response channels and the register map
// request port used by reg_cmd_sequencer.
//
// Handshake semantics (cmd and rsp channels): a transfer happens on a rising
// edge where valid and ready are both high. The producer holds valid and its
// payload stable until that edge. Ready may rise and fall independently of
// valid. On the register map side, a request (reg_rd_req/reg_wr_req) stays
// high until the map answers with ack_i or err_i, or until the sequencer
// gives up on the attempt.
interface reg_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_write_i;
    logic [ADDR_WIDTH-1:0] cmd_addr_i;
    logic [DATA_WIDTH-1:0] cmd_wdata_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic [1:0]            rsp_status_o;

    logic [ADDR_WIDTH-1:0] reg_addr;
    logic                  reg_rd_req;
    logic                  reg_wr_req;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic [DATA_WIDTH-1:0] reg_rd_data;
    logic                  ack_i;
    logic                  err_i;

    // Sequencer view.
    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_status_o,
        input  rsp_ready_i,
        output reg_addr, reg_rd_req, reg_wr_req, reg_wr_data,
        input  reg_rd_data, ack_i, err_i
    );

    // Host plus register map view.
    modport master (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_status_o,
        output rsp_ready_i,
        input  reg_addr, reg_rd_req, reg_wr_req, reg_wr_data,
        output reg_rd_data, ack_i, err_i
    );
endinterface

// File: rtl/reg_cmd_sequencer.sv
// Register command sequencer: takes one host command at a time, presents it
// to the register map, retries errored attempts, times out silent attempts
// and returns exactly one response per accepted command.
module reg_cmd_sequencer #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_RETRY   = 3,
    parameter int WAIT_CYCLES = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    reg_cmd_sequencer_if.slave   bus,
    output logic                 busy_o,
    output logic [7:0]           err_cnt_o,
    output logic [1:0]           dbg_state_o
);
    // WAIT_CYCLES >= 2 keeps WAIT_W >= 1; MAX_RETRY = 0 still needs one bit.
    localparam int WAIT_W  = $clog2(WAIT_CYCLES);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q,   state_d;
    logic                  write_q,   write_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            status_q,  status_d;
    logic [RETRY_W-1:0]    retry_q,   retry_d;
    logic [WAIT_W-1:0]     wait_q,    wait_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    // State and holding registers, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            status_q  <= ST_OK;
            retry_q   <= '0;
            wait_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            retry_q   <= retry_d;
            wait_q    <= wait_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next-state logic: capture, attempt outcome priority, gap, response drain.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
        retry_d   = retry_q;
        wait_d    = wait_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid_i) begin
                    write_d  = bus.cmd_write_i;
                    addr_d   = bus.cmd_addr_i;
                    wdata_d  = bus.cmd_wdata_i;
                    rdata_d  = '0;
                    status_d = ST_OK;
                    retry_d  = '0;
                    wait_d   = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // ack beats err when both arrive together.
                if (bus.ack_i) begin
                    rdata_d  = write_q ? '0 : bus.reg_rd_data;
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end else if (bus.err_i) begin
                    if (retry_q == RETRY_W'(MAX_RETRY)) begin
                        status_d = ST_ERR;
                        state_d  = S_RESP;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_GAP;
                    end
                end else if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
                    // A silent map is not retried.
                    status_d = ST_TIMEOUT;
                    state_d  = S_RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_GAP: begin
                // One idle cycle lets the map drop its in-flight tracking.
                wait_d  = '0;
                state_d = S_ISSUE;
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    if ((status_q != ST_OK) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs come from registers only.
    assign bus.cmd_ready_o  = (state_q == S_IDLE);
    assign bus.rsp_valid_o  = (state_q == S_RESP);
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.rsp_status_o = status_q;
    assign bus.reg_addr     = addr_q;
    assign bus.reg_wr_data  = wdata_q;
    assign bus.reg_rd_req   = (state_q == S_ISSUE) && !write_q;
    assign bus.reg_wr_req   = (state_q == S_ISSUE) && write_q;
    assign busy_o           = (state_q != S_IDLE);
    assign err_cnt_o        = err_cnt_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Bench for reg_cmd_sequencer: acts as host and register map, compares every
// response against a plan-driven reference model.
module tb_reg_cmd_sequencer;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int MR = 3;
    localparam int WC = 8;

    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_SIL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [7:0] err_cnt;
    logic [1:0] dbg_state;

    reg_cmd_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    reg_cmd_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_RETRY  (MR),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus.slave),
        .busy_o     (busy),
        .err_cnt_o  (err_cnt),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] mem [32];
    int plan_kind [MR+1];
    int plan_dly  [MR+1];
    int exp_err_cnt = 0;
    logic [DW+1:0] exp_q [$];   // {status, rdata}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: walk the attempt plan and return {status, rdata}.
    function automatic logic [DW+1:0] model_rsp(input logic wr, input logic [DW-1:0] rd_val,
                                                output int attempts);
        attempts = MR + 1;
        for (int k = 0; k <= MR; k++) begin
            if (plan_kind[k] == K_ACK) begin
                attempts = k + 1;
                return {2'b00, wr ? 8'h00 : rd_val};
            end
            if (plan_kind[k] == K_SIL) begin
                attempts = k + 1;
                return {2'b10, 8'h00};
            end
        end
        return {2'b01, 8'h00};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_plan_all(input int kind, input int dly);
        for (int k = 0; k <= MR; k++) begin
            plan_kind[k] = kind;
            plan_dly[k]  = dly;
        end
    endtask

    task automatic rand_plan();
        for (int k = 0; k <= MR; k++) begin
            int r;
            r = int'($urandom_range(0, 9));
            plan_kind[k] = (r < 4) ? K_ACK : (r < 8) ? K_ERR : K_SIL;
            plan_dly[k]  = int'($urandom_range(0, WC - 1));
        end
    endtask

    // Runs one full command from an IDLE negedge back to the next IDLE negedge.
    task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int hold, input logic junk);
        int attempts;
        int last_c;
        logic [DW+1:0] exp;
        logic [DW+1:0] got;

        exp = model_rsp(wr, mem[a], attempts);
        exp_q.push_back(exp);

        check("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = wr;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = wd;
        @(negedge clk);
        // Fields may change after the handshake; valid is ignored while busy.
        bus.cmd_valid_i = junk;
        bus.cmd_write_i = 1'($urandom);
        bus.cmd_addr_i  = AW'($urandom);
        bus.cmd_wdata_i = DW'($urandom);

        for (int k = 0; k < attempts; k++) begin
            last_c = (plan_kind[k] == K_SIL) ? WC - 1 : plan_dly[k];
            for (int c = 0; c <= last_c; c++) begin
                check("rd_req", 32'(bus.reg_rd_req), 32'(!wr));
                check("wr_req", 32'(bus.reg_wr_req), 32'(wr));
                check("reg_addr", 32'(bus.reg_addr), 32'(a));
                if (wr) check("reg_wr_data", 32'(bus.reg_wr_data), 32'(wd));
                check("cmd_ready_busy", 32'(bus.cmd_ready_o), 32'd0);
                bus.reg_rd_data = DW'($urandom);
                if (c == last_c && plan_kind[k] == K_ACK) begin
                    bus.ack_i = 1'b1;
                    bus.err_i = 1'($urandom_range(0, 1));
                    if (wr) mem[a] = wd;
                    else    bus.reg_rd_data = mem[a];
                end else if (c == last_c && plan_kind[k] == K_ERR) begin
                    bus.err_i = 1'b1;
                end
                @(negedge clk);
                bus.ack_i = 1'b0;
                bus.err_i = 1'b0;
            end
            if (k < attempts - 1) begin
                check("gap_rd_req", 32'(bus.reg_rd_req), 32'd0);
                check("gap_wr_req", 32'(bus.reg_wr_req), 32'd0);
                check("gap_busy", 32'(busy), 32'd1);
                @(negedge clk);
            end
        end

        check("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("resp_rd_req", 32'(bus.reg_rd_req), 32'd0);
        check("resp_wr_req", 32'(bus.reg_wr_req), 32'd0);
        got = {bus.rsp_status_o, bus.rsp_rdata_o};
        exp = exp_q.pop_front();
        check("rsp", 32'(got), 32'(exp));

        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid_i = 1'b1;
            bus.cmd_write_i = 1'($urandom);
            bus.cmd_addr_i  = AW'($urandom);
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("hold_rsp", 32'({bus.rsp_status_o, bus.rsp_rdata_o}), 32'(exp));
            check("hold_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
            check("hold_req", 32'(bus.reg_rd_req | bus.reg_wr_req), 32'd0);
        end

        bus.cmd_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        if (exp[DW+1:DW] != 2'b00 && exp_err_cnt < 255) exp_err_cnt++;
        check("done_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("done_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_req", 32'(bus.reg_rd_req | bus.reg_wr_req), 32'd0);
        check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    endtask

    // Reset lands during the third cycle of an attempt; the command is dropped.
    task automatic reset_mid();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 5'h03;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        check("rst_issue1", 32'(bus.reg_rd_req), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("rst_issue3", 32'(bus.reg_rd_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err_cnt = 0;
        check("rst_rd_req", 32'(bus.reg_rd_req), 32'd0);
        check("rst_wr_req", 32'(bus.reg_wr_req), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(bus.reg_addr), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
            check("rst_idle", 32'(bus.cmd_ready_o), 32'd1);
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        bus.cmd_valid_i = 1'b0;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = '0;
        bus.cmd_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        bus.reg_rd_data = '0;
        bus.ack_i       = 1'b0;
        bus.err_i       = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
        mem[2] = 8'hA5;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        check("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("reset_req", 32'(bus.reg_rd_req | bus.reg_wr_req), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_addr", 32'(bus.reg_addr), 32'd0);
        check("reset_wr_data", 32'(bus.reg_wr_data), 32'd0);
        check("reset_rsp", 32'({bus.rsp_status_o, bus.rsp_rdata_o}), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);

        // Read with immediate ack.
        set_plan_all(K_ACK, 0);
        do_cmd(1'b0, 5'h02, 8'h00, 0, 1'b0);
        // Write that errors on every attempt.
        set_plan_all(K_ERR, 0);
        do_cmd(1'b1, 5'h01, 8'h3C, 0, 1'b0);
        // Write into a silent map.
        set_plan_all(K_SIL, 0);
        do_cmd(1'b1, 5'h00, 8'h01, 0, 1'b0);
        // Read that errors once, then succeeds.
        mem[7] = 8'h5A;
        set_plan_all(K_ACK, 2);
        plan_kind[0] = K_ERR;
        plan_dly[0]  = 3;
        do_cmd(1'b0, 5'h07, 8'h00, 0, 1'b0);
        // Response back-pressure with a pending command.
        set_plan_all(K_ACK, 1);
        do_cmd(1'b0, 5'h02, 8'h00, 5, 1'b1);
        // Error on the last cycle of the wait window still retries.
        set_plan_all(K_ACK, 0);
        plan_kind[0] = K_ERR;
        plan_dly[0]  = WC - 1;
        do_cmd(1'b1, 5'h09, 8'hC3, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            rand_plan();
            do_cmd(1'($urandom), AW'($urandom), DW'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        reset_mid();

        set_plan_all(K_ERR, 0);
        for (int n = 0; n < 258; n++) begin
            do_cmd(1'($urandom), AW'($urandom), DW'($urandom), 0, 1'b0);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
